// File: rtl/rggen_w01c_clear_scheduler.sv
// Round-robin service scheduler for a w01c status field: requests service of one
// pending bit at a time, then clears it through the field's shared write port.
module rggen_w01c_clear_scheduler #(
  parameter int         WIDTH       = 8,
  parameter int         ID_WIDTH    = 3,
  parameter logic [1:0] CLEAR_VALUE = 2'b00
)(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [WIDTH-1:0]    i_pending,
  input  logic                i_sw_valid,
  input  logic [WIDTH-1:0]    i_sw_write_mask,
  input  logic [WIDTH-1:0]    i_sw_write_data,
  output logic                o_bit_field_valid,
  output logic [WIDTH-1:0]    o_bit_field_write_mask,
  output logic [WIDTH-1:0]    o_bit_field_write_data,
  output logic                o_req,
  output logic [ID_WIDTH-1:0] o_req_id,
  input  logic                i_ack,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [ID_WIDTH-1:0] req_id_q, req_id_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0]    at_or_above_ptr;
  logic [WIDTH-1:0]    upper_pending;
  logic [WIDTH-1:0]    onehot;
  logic [WIDTH-1:0]    clear_data;
  logic [ID_WIDTH-1:0] sel_idx;
  logic [ID_WIDTH-1:0] id_inc;
  logic                clear_issue;

  generate
    if ((WIDTH < 2) || (WIDTH > 64) || (ID_WIDTH < $clog2(WIDTH))) begin : g_bad_params
      // Deliberately out-of-range select so illegal sizing stops elaboration.
      localparam logic [0:0] SIZE_OK  = 1'b0;
      localparam logic       SIZE_BAD = SIZE_OK[WIDTH];
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign at_or_above_ptr[gi] = (ID_WIDTH'(gi) >= ptr_q);
      assign onehot[gi]          = (req_id_q == ID_WIDTH'(gi));
    end

    if (CLEAR_VALUE == 2'b00) begin : g_write0_clear
      assign clear_data = ~onehot;
    end else if (CLEAR_VALUE == 2'b01) begin : g_write1_clear
      assign clear_data = onehot;
    end else begin : g_illegal_clear_value
      localparam logic [1:0] LEGAL_ENCODINGS = 2'b11;
      assign clear_data = {WIDTH{LEGAL_ENCODINGS[CLEAR_VALUE + 2]}};
    end
  endgenerate

  function automatic logic [ID_WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] v);
    lowest_set = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (v[k]) lowest_set = ID_WIDTH'(k);
    end
  endfunction

  // Bits at or above ptr take precedence; otherwise wrap to the lowest set bit.
  assign upper_pending = i_pending & at_or_above_ptr;
  assign sel_idx       = (|upper_pending) ? lowest_set(upper_pending) : lowest_set(i_pending);
  assign id_inc        = (req_id_q == ID_WIDTH'(WIDTH - 1)) ? '0 : req_id_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      req_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      req_id_q <= req_id_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    req_id_d    = req_id_q;
    ptr_d       = ptr_q;
    clear_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|i_pending) begin
          req_d    = 1'b1;
          req_id_d = sel_idx;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (i_ack) begin
          req_d   = 1'b0;
          ptr_d   = id_inc;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // Software owns the write port whenever it is active.
        if (!i_sw_valid) begin
          clear_issue = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_bit_field_valid      = clear_issue | i_sw_valid;
  assign o_bit_field_write_mask = clear_issue ? onehot : i_sw_write_mask;
  assign o_bit_field_write_data = clear_issue ? clear_data : i_sw_write_data;
  assign o_req                  = req_q;
  assign o_req_id               = req_id_q;
  assign o_busy                 = (state_q != IDLE);

endmodule
